// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
// Contents: FSM state encoding, default port count, header address width.
// Imported by router_fsm; holds no logic of its own.
package router_pkg;

    // Header address field width; the router never decodes more than 2 bits.
    localparam int ADDR_W        = 2;
    localparam int NUM_PORTS_DEF = 3;

    // 3-bit binary encoding; every encoding is a named state, but the
    // next-state logic still falls back to DA on anything unexpected.
    typedef enum logic [2:0] {
        DA  = 3'd0,   // decode address (idle, waiting for header)
        LFD = 3'd1,   // load first data (header word)
        LD  = 3'd2,   // load payload
        LP  = 3'd3,   // load parity
        CPE = 3'd4,   // check parity error
        FFS = 3'd5,   // fifo full stall
        LAF = 3'd6,   // load after full
        WTE = 3'd7    // wait till destination fifo empty
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Purpose: Moore controller sequencing one packet at a time into the destination FIFOs.
// Latency: header accepted in DA -> lfd_state next cycle; min packet (1 payload byte) is 5 cycles.
// Backpressure: busy stalls the source in every state but DA/LD; full/drain handled via FFS/WTE.
// Ports: clock/resetn (async active-low); pkt_valid, data_in, fifo_full, fifo_empty,
//        soft_reset, parity_done, low_pkt_valid in; busy, detect_add, lfd_state,
//        ld_state, laf_state, full_state, write_enb_reg, rst_int_reg out.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg
);

    localparam int               SEL_N     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  PORTS_LIM = (ADDR_W + 1)'(NUM_PORTS);

    state_t              state_q;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [SEL_N-1:0]    empty_pad;
    logic [SEL_N-1:0]    sreset_pad;
    logic                addr_ok;

    // Per-port flags zero-extended to the full address space so any 2-bit
    // address indexes a defined bit; unused ports read as not-empty/no-reset.
    always_comb begin
        empty_pad                   = '0;
        sreset_pad                  = '0;
        empty_pad[NUM_PORTS-1:0]    = fifo_empty;
        sreset_pad[NUM_PORTS-1:0]   = soft_reset;
    end

    // Headers addressing a non-existent port are dropped by staying in DA.
    assign addr_ok = ({1'b0, data_in} < PORTS_LIM);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DA;
            addr_q  <= '0;
        end else begin
            state_q <= state_nxt;
            // Latch the destination only on the cycle the header is accepted.
            if (state_q == DA && state_nxt != DA) begin
                addr_q <= data_in;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            DA: begin
                if (pkt_valid && addr_ok) begin
                    state_nxt = empty_pad[data_in] ? LFD : WTE;
                end
            end
            LFD: state_nxt = LD;
            LD: begin
                // A full FIFO outranks end-of-packet: the last byte must wait.
                if (fifo_full) begin
                    state_nxt = FFS;
                end else if (!pkt_valid) begin
                    state_nxt = LP;
                end
            end
            FFS: begin
                if (!fifo_full) begin
                    state_nxt = LAF;
                end
            end
            LAF: begin
                // Parity already captured during the stall ends the packet outright.
                if (parity_done) begin
                    state_nxt = DA;
                end else if (low_pkt_valid) begin
                    state_nxt = LP;
                end else begin
                    state_nxt = LD;
                end
            end
            LP:  state_nxt = CPE;
            CPE: state_nxt = fifo_full ? FFS : DA;
            WTE: begin
                if (empty_pad[addr_q]) begin
                    state_nxt = LFD;
                end
            end
            default: state_nxt = DA;
        endcase

        // Timeout soft reset of the selected FIFO aborts the packet from any state.
        if (state_q != DA && sreset_pad[addr_q]) begin
            state_nxt = DA;
        end
    end

    // Moore outputs: pure decode of the state register.
    assign detect_add    = (state_q == DA);
    assign lfd_state     = (state_q == LFD);
    assign ld_state      = (state_q == LD);
    assign laf_state     = (state_q == LAF);
    assign full_state    = (state_q == FFS);
    assign rst_int_reg   = (state_q == CPE);
    assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
    assign busy          = !((state_q == DA) || (state_q == LD));

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with an in-bench packet-phase model.
// The model advances on each posedge from the same inputs; outputs compared every negedge.
// Literal checks at key points pin the model to hand-derived values.
module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg;

    int checks = 0;
    int errors = 0;

    router_fsm #(.NUM_PORTS(3)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packet phases as the source sees them.
    typedef enum int {P_IDLE, P_HEADER, P_PAYLOAD, P_PARITY, P_CHECK,
                      P_STALL, P_RESUME, P_WAITEMPTY} phase_t;

    phase_t m_ph;
    int     m_addr;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_ph   = P_IDLE;
            m_addr = 0;
        end else if (m_ph != P_IDLE && soft_reset[m_addr]) begin
            m_ph = P_IDLE;
        end else begin
            case (m_ph)
                P_IDLE: if (pkt_valid && data_in < 2'd3) begin
                    m_addr = int'(data_in);
                    m_ph   = fifo_empty[m_addr] ? P_HEADER : P_WAITEMPTY;
                end
                P_HEADER:    m_ph = P_PAYLOAD;
                P_PAYLOAD:   if (fifo_full) m_ph = P_STALL;
                             else if (!pkt_valid) m_ph = P_PARITY;
                P_STALL:     if (!fifo_full) m_ph = P_RESUME;
                P_RESUME:    m_ph = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_PAYLOAD);
                P_PARITY:    m_ph = P_CHECK;
                P_CHECK:     m_ph = fifo_full ? P_STALL : P_IDLE;
                P_WAITEMPTY: if (fifo_empty[m_addr]) m_ph = P_HEADER;
                default:     m_ph = P_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every cycle: the source may send only in idle or payload; bytes are written
    // in payload, parity and resume.
    always @(negedge clock) begin
        chk("busy",       busy,          !(m_ph inside {P_IDLE, P_PAYLOAD}));
        chk("detect_add", detect_add,    m_ph == P_IDLE);
        chk("lfd_state",  lfd_state,     m_ph == P_HEADER);
        chk("ld_state",   ld_state,      m_ph == P_PAYLOAD);
        chk("laf_state",  laf_state,     m_ph == P_RESUME);
        chk("full_state", full_state,    m_ph == P_STALL);
        chk("write_enb",  write_enb_reg, m_ph inside {P_PAYLOAD, P_PARITY, P_RESUME});
        chk("rst_int",    rst_int_reg,   m_ph == P_CHECK);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Walk a packet from DA into LAF via one full stall (pkt_valid/data_in preset).
    task automatic to_laf();
        tick(2);                       // LFD, LD
        fifo_full = 1'b1; tick(1);     // FFS
        fifo_full = 1'b0; tick(1);     // LAF
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        #1;
        chk("rst_detect_add", detect_add, 1'b1);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_write_enb",  write_enb_reg, 1'b0);
        tick(2);
        resetn = 1'b1;

        // 1: minimum packet to port 1
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(1); chk("t1_lfd", lfd_state, 1'b1); chk("t1_lfd_busy", busy, 1'b1);
        tick(1); chk("t1_ld_wen", write_enb_reg, 1'b1); chk("t1_ld_busy", busy, 1'b0);
        pkt_valid = 1'b0;
        tick(1); chk("t1_lp_wen", write_enb_reg, 1'b1);
        tick(1); chk("t1_cpe", rst_int_reg, 1'b1);
        tick(1); chk("t1_da", detect_add, 1'b1);

        // 2: destination not empty -> wait, then header
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
        tick(1); pkt_valid = 1'b0; data_in = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_wte_busy", busy, 1'b1);
            tick(1);
        end
        fifo_empty = 3'b111;
        tick(1); chk("t2_lfd", lfd_state, 1'b1);
        pkt_valid = 1'b1;
        tick(1); chk("t2_ld", ld_state, 1'b1);

        // 3: full stall for 3 cycles, resume, low_pkt_valid -> parity
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1); chk("t3_full", full_state, 1'b1);
        end
        fifo_full = 1'b0;
        tick(1); chk("t3_laf", laf_state, 1'b1);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        tick(1); chk("t3_lp_wen", write_enb_reg, 1'b1); chk("t3_lp_busy", busy, 1'b1);
        low_pkt_valid = 1'b0;
        tick(2); chk("t3_da", detect_add, 1'b1);

        // 4: LAF priorities, then CPE with full FIFO
        pkt_valid = 1'b1; data_in = 2'd0;
        to_laf();
        parity_done = 1'b1; low_pkt_valid = 1'b1;
        tick(1); chk("t4_parity_wins", detect_add, 1'b1);
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        to_laf();
        tick(1); chk("t4_back_to_ld", ld_state, 1'b1);
        pkt_valid = 1'b0;
        tick(2); chk("t4_cpe", rst_int_reg, 1'b1);
        fifo_full = 1'b1;
        tick(1); chk("t4_cpe_to_ffs", full_state, 1'b1);
        fifo_full = 1'b0;
        tick(1); parity_done = 1'b1;
        tick(1); chk("t4_laf_done", detect_add, 1'b1);
        parity_done = 1'b0;

        // 5: address 3 dropped; soft reset only on the selected port
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick(1); chk("t5_drop", detect_add, 1'b1);
        end
        data_in = 2'd0; fifo_empty = 3'b110;
        tick(1); chk("t5_wte", busy, 1'b1);
        pkt_valid = 1'b0; soft_reset = 3'b010;
        tick(1); chk("t5_other_sr", detect_add, 1'b0);
        soft_reset = 3'b001;
        tick(1); chk("t5_sel_sr", detect_add, 1'b1);
        soft_reset = 3'b000; fifo_empty = 3'b111;

        // 6: asynchronous reset mid-LD
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(2); chk("t6_in_ld", ld_state, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_async_da",  detect_add,    1'b1);
        chk("t6_async_wen", write_enb_reg, 1'b0);
        tick(1);
        resetn = 1'b1; pkt_valid = 1'b0;
        tick(2);
        chk("t6_idle", detect_add, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
